nanov_serial_sequencer: RTL and testbench

- Control sequencer for the nanoV bit-serial ALU/register datapath.
- Accepts one instruction per handshake and steps a 5-bit bit counter through 32 bit-cycles, LSB first.
- Drives ALU op, operand select, immediate bit, carry-in, register addresses and write enable.
- Adds a two-pass flow so SLT/SLTU can write their compare result.

---
 rtl/nanov_serial_sequencer.sv | 169 ++++++++++++++++
 tb/tb_nanov_serial_sequencer.sv | 333 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/nanov_serial_sequencer.sv
// nanoV bit-serial control sequencer: one instruction per handshake, 32 LSB-first bit-cycles.
// Macro NANOV_SLT_EN builds the two-pass CMP/SLTW flow so SLT/SLTU can write their result.
module nanov_serial_sequencer #(
  parameter int unsigned REG_AW = 4,
  parameter int unsigned IMM_W  = 12
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              instr_valid,
  output logic              instr_ready,
  input  logic [31:0]       instr,
  input  logic              stall,
  output logic [4:0]        counter,
  output logic [REG_AW-1:0] rs1,
  output logic [REG_AW-1:0] rs2,
  output logic [REG_AW-1:0] rd,
  output logic [3:0]        alu_op,
  output logic              alu_select_rs2,
  output logic              alu_imm_bit,
  output logic              cy_in,
  input  logic              cy_out,
  input  logic              lts,
  output logic              rd_wr_en,
  output logic              rd_force,
  output logic              rd_force_bit,
  output logic              store_en,
  output logic              done
);

  localparam int unsigned XLEN = 32;
  localparam int unsigned CW   = 5;
  localparam logic [6:0]  OPC_STORE = 7'b0100011;
  localparam logic [4:0]  OPC_ALU   = 5'b10011;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_CMP  = 2'd2,
    S_SLTW = 2'd3
  } state_e;

  state_e          state_q, state_d;
  logic [CW-1:0]   counter_q, counter_d;
  logic            cy_q, cy_d;
  logic [XLEN-1:0] instr_q, instr_d;
  logic            done_q, done_d;
`ifdef NANOV_SLT_EN
  logic            lt_q, lt_d;
`endif

  logic [2:0]      funct3;
  logic            is_alu;
  logic            is_slt;
  logic            rd_nz;
  logic            last_bit;
  logic [XLEN-1:0] imm_ext;
  logic            unused_ok;

  assign funct3   = instr_q[14:12];
  assign is_alu   = (instr_q[4:0] == OPC_ALU);
  assign is_slt   = is_alu && (funct3[2:1] == 2'b01);
  assign rd_nz    = |rd;
  assign last_bit = (counter_q == CW'(XLEN - 1));
  assign imm_ext  = {{(XLEN - IMM_W){instr_q[31]}}, instr_q[31 -: IMM_W]};
  assign unused_ok = ^{instr_q, lts};

  assign counter        = counter_q;
  assign rs1            = instr_q[15 +: REG_AW];
  assign rs2            = instr_q[20 +: REG_AW];
  assign rd             = instr_q[7 +: REG_AW];
  assign alu_op         = {instr_q[30] & instr_q[5], funct3};
  assign alu_select_rs2 = instr_q[5] & instr_q[4];

  // State, bit counter, carry and latched instruction
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q   <= S_IDLE;
      counter_q <= '0;
      cy_q      <= 1'b0;
      instr_q   <= '0;
      done_q    <= 1'b0;
`ifdef NANOV_SLT_EN
      lt_q      <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      counter_q <= counter_d;
      cy_q      <= cy_d;
      instr_q   <= instr_d;
      done_q    <= done_d;
`ifdef NANOV_SLT_EN
      lt_q      <= lt_d;
`endif
    end
  end

  // Next-state: a pending done survives only while stalled
  always_comb begin
    state_d   = state_q;
    counter_d = counter_q;
    cy_d      = cy_q;
    instr_d   = instr_q;
    done_d    = done_q & stall;
`ifdef NANOV_SLT_EN
    lt_d      = lt_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (instr_valid) begin
          instr_d   = instr;
          counter_d = '0;
          state_d   = S_EXEC;
`ifdef NANOV_SLT_EN
          if ((instr[4:0] == OPC_ALU) && (instr[14:13] == 2'b01)) begin
            state_d = S_CMP;
          end
`endif
        end
      end
      default: begin
        if (!stall) begin
          counter_d = counter_q + CW'(1);
          cy_d      = cy_out;
          if (last_bit) begin
            case (state_q)
`ifdef NANOV_SLT_EN
              S_CMP: begin
                state_d = S_SLTW;
                lt_d    = funct3[0] ? ~cy_out : lts;
              end
`endif
              default: begin
                state_d = S_IDLE;
                done_d  = 1'b1;
              end
            endcase
          end
        end
      end
    endcase
  end

  // Datapath controls decoded from state and latched instruction
  always_comb begin
    instr_ready  = (state_q == S_IDLE);
    rd_wr_en     = 1'b0;
    store_en     = 1'b0;
    rd_force     = 1'b0;
    rd_force_bit = 1'b0;
    case (state_q)
      S_EXEC: begin
        rd_wr_en = !stall && is_alu && !is_slt && rd_nz;
        store_en = !stall && (instr_q[6:0] == OPC_STORE);
      end
`ifdef NANOV_SLT_EN
      S_SLTW: begin
        rd_force     = 1'b1;
        rd_wr_en     = !stall && rd_nz;
        rd_force_bit = lt_q && (counter_q == '0);
      end
`endif
      default: ;
    endcase
    cy_in       = (counter_q == '0) ? (alu_op[1] | alu_op[3]) : cy_q;
    alu_imm_bit = imm_ext[counter_q];
    done        = done_q & ~stall;
  end

endmodule

// File: tb/tb_nanov_serial_sequencer.sv
// Bench for nanov_serial_sequencer: serial datapath emulation, per-cycle behavioural model, directed and random runs.
module tb_nanov_serial_sequencer;

`ifdef NANOV_SLT_EN
  localparam bit SLT_EN = 1'b1;
`else
  localparam bit SLT_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        instr_valid = 1'b0;
  logic [31:0] instr = '0;
  logic        stall = 1'b0;
  logic        instr_ready;
  logic [4:0]  counter;
  logic [3:0]  rs1, rs2, rd;
  logic [3:0]  alu_op;
  logic        alu_select_rs2, alu_imm_bit, cy_in, cy_out, lts;
  logic        rd_wr_en, rd_force, rd_force_bit, store_en, done;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  nanov_serial_sequencer #(.REG_AW(4), .IMM_W(12)) dut (
    .clk(clk), .rstn(rstn), .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instr(instr), .stall(stall), .counter(counter), .rs1(rs1), .rs2(rs2), .rd(rd),
    .alu_op(alu_op), .alu_select_rs2(alu_select_rs2), .alu_imm_bit(alu_imm_bit),
    .cy_in(cy_in), .cy_out(cy_out), .lts(lts), .rd_wr_en(rd_wr_en), .rd_force(rd_force),
    .rd_force_bit(rd_force_bit), .store_en(store_en), .done(done)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
    end
  endtask

  // Serial ALU and register file driven by the sequencer's controls
  logic [31:0] regs [16];
  logic        seed_en = 1'b0;
  logic [3:0]  seed_idx = '0;
  logic [31:0] seed_val = '0;
  logic        a_bit, b_raw, b_bit, sub_op, sum_bit, wdata;

  always_comb begin
    a_bit   = regs[rs1][counter];
    b_raw   = alu_select_rs2 ? regs[rs2][counter] : alu_imm_bit;
    sub_op  = alu_op[3] | (alu_op[2:1] == 2'b01);
    b_bit   = b_raw ^ sub_op;
    sum_bit = a_bit ^ b_bit ^ cy_in;
    cy_out  = (a_bit & b_bit) | (a_bit & cy_in) | (b_bit & cy_in);
    lts     = (a_bit != b_raw) ? a_bit : sum_bit;
    wdata   = rd_force ? rd_force_bit : sum_bit;
  end

  always @(posedge clk) begin
    if (seed_en) regs[seed_idx] <= seed_val;
    else if (rd_wr_en) regs[rd][counter] <= wdata;
  end

  // Behavioural model: instruction-level expectations, bit-cycle index k
  bit          m_busy = 0, m_pend = 0, m_slt2 = 0, m_wr_exec = 0, m_store = 0, m_lt = 0;
  bit          m_cin0 = 0, m_prev_cy = 0, m_chk_sel = 0, m_sel = 0;
  int          m_k = 0, m_total = 32;
  logic [31:0] m_instr = '0, m_imm = '0, m_exp = '0;
  logic [3:0]  m_rd = '0;

  always @(negedge clk) begin
    logic [6:0]  op;
    logic [2:0]  f3;
    logic [31:0] a, b, val;
    bit          alu_cls, slt_cls, add_cls, wr_val;
    int          c, pass;
    if (!rstn) begin
      chk("rst_ready", instr_ready, 1);
      chk("rst_counter", counter, 0);
      chk("rst_wr", rd_wr_en, 0);
      chk("rst_force", rd_force, 0);
      chk("rst_store", store_en, 0);
      chk("rst_done", done, 0);
      m_busy = 0;
      m_pend = 0;
    end else if (!m_busy) begin
      chk("idle_ready", instr_ready, 1);
      chk("idle_wr", rd_wr_en, 0);
      chk("idle_store", store_en, 0);
      chk("idle_done", done, m_pend && !stall);
      if (m_pend && !stall) begin
        chk("result", regs[m_rd], m_exp);
        m_pend = 0;
      end
      if (instr_valid) begin
        op = instr[6:0];
        f3 = instr[14:12];
        m_instr = instr;
        m_rd = instr[10:7];
        m_imm = {{20{instr[31]}}, instr[31:20]};
        alu_cls = (instr[4:0] == 5'b10011);
        slt_cls = alu_cls && (f3[2:1] == 2'b01);
        add_cls = alu_cls && (f3 == 3'b000);
        a = regs[instr[18:15]];
        b = (op == 7'h33) ? regs[instr[23:20]] : m_imm;
        m_lt = f3[0] ? (a < b) : ($signed(a) < $signed(b));
        val = '0;
        wr_val = 0;
        if (add_cls) begin
          val = (op == 7'h33 && instr[30]) ? a - b : a + b;
          wr_val = 1;
        end else if (slt_cls && SLT_EN) begin
          val = {31'b0, m_lt};
          wr_val = 1;
        end
        m_exp = (wr_val && m_rd != 0) ? val : regs[m_rd];
        m_slt2 = slt_cls && SLT_EN;
        m_total = m_slt2 ? 64 : 32;
        m_wr_exec = alu_cls && !slt_cls && (m_rd != 0);
        m_store = (op == 7'b0100011);
        m_cin0 = f3[1] | (instr[30] & instr[5]);
        m_chk_sel = alu_cls;
        m_sel = (op == 7'h33);
        m_k = 0;
        m_busy = 1;
      end
    end else begin
      c = m_k % 32;
      pass = m_k / 32;
      chk("counter", counter, c);
      chk("busy_ready", instr_ready, 0);
      chk("busy_done", done, 0);
      chk("rd", rd, m_rd);
      chk("rs1", rs1, m_instr[18:15]);
      chk("rs2", rs2, m_instr[23:20]);
      chk("alu_op", alu_op, {m_instr[30] & m_instr[5], m_instr[14:12]});
      if (m_chk_sel) chk("alu_sel", alu_select_rs2, m_sel);
      chk("imm_bit", alu_imm_bit, (m_imm >> c) & 32'd1);
      chk("cy_in", cy_in, (c == 0) ? m_cin0 : m_prev_cy);
      if (m_slt2) begin
        chk("wr", rd_wr_en, (pass == 1) && !stall && (m_rd != 0));
        chk("force", rd_force, pass == 1);
        chk("force_bit", rd_force_bit, (pass == 1) && (c == 0) && m_lt);
        chk("store", store_en, 0);
      end else begin
        chk("wr", rd_wr_en, m_wr_exec && !stall);
        chk("force", rd_force, 0);
        chk("store", store_en, m_store && !stall);
      end
      if (!stall) begin
        m_prev_cy = cy_out;
        m_k++;
        if (m_k == m_total) begin
          m_busy = 0;
          m_pend = 1;
        end
      end
    end
  end

  task automatic set_reg(input int idx, input logic [31:0] v);
    @(posedge clk); #1;
    seed_idx = 4'(idx);
    seed_val = v;
    seed_en = 1'b1;
    @(posedge clk); #1;
    seed_en = 1'b0;
  endtask

  // mode 0: no stall, 1: stall stall_len cycles at counter stall_at, 2: random stalls
  task automatic run(input logic [31:0] ins, input int mode, input int stall_at, input int stall_len,
                     output int lat, output int nstall, output int nwr, output int nstore,
                     output logic [31:0] imm_seen, output logic cy0);
    int left;
    lat = 0; nstall = 0; nwr = 0; nstore = 0; imm_seen = '0; cy0 = 1'b0;
    left = stall_len;
    @(posedge clk); #1;
    instr = ins;
    instr_valid = 1'b1;
    stall = 1'b0;
    while (1) begin
      @(posedge clk); lat++; #1;
      if (lat == 1) instr_valid = 1'b0;
      stall = 1'b0;
      if (mode == 1 && left > 0 && !instr_ready && counter == 5'(stall_at)) begin
        stall = 1'b1;
        left--;
      end else if (mode == 2) begin
        stall = ($urandom_range(0, 4) == 0);
      end
      if (stall) nstall++;
      @(negedge clk);
      if (mode == 1 && stall) chk("stall_hold", counter, 5'(stall_at));
      if (!instr_ready) begin
        imm_seen[counter] = alu_imm_bit;
        if (rd_wr_en) nwr++;
        if (store_en) nstore++;
      end
      if (lat == 1) cy0 = cy_in;
      if (done) break;
      if (lat > 400) begin
        checks++;
        failures++;
        $display("FAIL done_timeout actual=%0d required<=400 cycles", lat);
        break;
      end
    end
    stall = 1'b0;
  endtask

  initial begin
    #200_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat, ns, nw, nst;
    logic [31:0] imms, ins;
    logic cy0;
    #1;
    chk("reset_ready", instr_ready, 1);
    chk("reset_done", done, 0);
    repeat (3) @(posedge clk);
    #1 rstn = 1'b1;
    for (int i = 0; i < 16; i++) set_reg(i, (i == 0) ? 32'd0 : $urandom);

    // ADDI x1,x0,5
    run(32'h00500093, 0, 0, 0, lat, ns, nw, nst, imms, cy0);
    chk("addi_lat", lat, 33);
    chk("addi_x1", regs[1], 32'd5);
    chk("addi_imm_bits", imms, 32'h5);
    chk("addi_wr_cycles", nw, 32);
    chk("addi_ready", instr_ready, 1);

    // SUB x3,x1,x2
    set_reg(1, 32'd7);
    set_reg(2, 32'd9);
    run(32'h402081B3, 0, 0, 0, lat, ns, nw, nst, imms, cy0);
    chk("sub_cy0", cy0, 1);
    chk("sub_lat", lat, 33);
    chk("sub_x3", regs[3], 32'hFFFFFFFE);

    // SLTU x4,x1,x2
    set_reg(1, 32'd3);
    set_reg(2, 32'hFFFFFFFF);
    set_reg(4, 32'hA5A5A5A5);
    run(32'h0020B233, 0, 0, 0, lat, ns, nw, nst, imms, cy0);
    chk("sltu_lat", lat, SLT_EN ? 65 : 33);
    chk("sltu_x4", regs[4], SLT_EN ? 32'h1 : 32'hA5A5A5A5);
    chk("sltu_wr_cycles", nw, SLT_EN ? 32 : 0);

    // SLT x5,x1,x2 both orderings
    set_reg(5, 32'h77);
    set_reg(1, 32'hFFFFFFFF);
    set_reg(2, 32'd1);
    run(32'h0020A2B3, 0, 0, 0, lat, ns, nw, nst, imms, cy0);
    chk("slt_neg_x5", regs[5], SLT_EN ? 32'h1 : 32'h77);
    set_reg(1, 32'd1);
    set_reg(2, 32'hFFFFFFFF);
    run(32'h0020A2B3, 0, 0, 0, lat, ns, nw, nst, imms, cy0);
    chk("slt_pos_x5", regs[5], SLT_EN ? 32'h0 : 32'h77);

    // ADDI with 3 stall cycles at counter 10
    set_reg(1, 32'h0000DEAD);
    run(32'h00500093, 1, 10, 3, lat, ns, nw, nst, imms, cy0);
    chk("stall_lat", lat, 36);
    chk("stall_x1", regs[1], 32'd5);
    chk("stall_wr_cycles", nw, 32);

    // SW x2,0(x1)
    run(32'h0020A023, 0, 0, 0, lat, ns, nw, nst, imms, cy0);
    chk("sw_store_cycles", nst, 32);
    chk("sw_wr_cycles", nw, 0);

    // Reset at counter 5 of ADDI x6,x0,-1: only bits 0..4 were written
    set_reg(6, 32'd0);
    @(posedge clk); #1;
    instr = 32'hFFF00313;
    instr_valid = 1'b1;
    @(posedge clk); #1;
    instr_valid = 1'b0;
    for (int i = 0; i < 100 && counter != 5'd5; i++) begin
      @(posedge clk); #1;
    end
    rstn = 1'b0;
    #1;
    chk("rstmid_counter", counter, 0);
    chk("rstmid_ready", instr_ready, 1);
    chk("rstmid_wr", rd_wr_en, 0);
    chk("rstmid_done", done, 0);
    chk("rstmid_rd", rd, 0);
    @(negedge clk);
    @(posedge clk); #1;
    rstn = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rstmid_x6", regs[6], 32'h0000001F);

    // Randomised instruction mix with random stalls
    for (int n = 0; n < 60; n++) begin
      logic [3:0]  r1, r2, rdd;
      logic [11:0] im;
      int          cls, base;
      r1 = 4'($urandom);
      r2 = 4'($urandom);
      rdd = 4'($urandom);
      im = 12'($urandom);
      cls = $urandom_range(0, 7);
      base = 33;
      case (cls)
        0: ins = {im, 1'b0, r1, 3'b000, 1'b0, rdd, 7'h13};
        1: ins = {7'h00, 1'b0, r2, 1'b0, r1, 3'b000, 1'b0, rdd, 7'h33};
        2: ins = {7'h20, 1'b0, r2, 1'b0, r1, 3'b000, 1'b0, rdd, 7'h33};
        3: ins = {7'h00, 1'b0, r2, 1'b0, r1, 3'b010, 1'b0, rdd, 7'h33};
        4: ins = {7'h00, 1'b0, r2, 1'b0, r1, 3'b011, 1'b0, rdd, 7'h33};
        5: ins = {im, 1'b0, r1, 2'b01, im[0], 1'b0, rdd, 7'h13};
        6: ins = {im[11:5], 1'b0, r2, 1'b0, r1, 3'b010, im[4:0], 7'h23};
        default: ins = {im, 1'b0, r1, 3'b000, 1'b0, rdd, 7'h0B};
      endcase
      if (SLT_EN && cls >= 3 && cls <= 5) base = 65;
      run(ins, 2, 0, 0, lat, ns, nw, nst, imms, cy0);
      chk("rand_lat", lat, base + ns);
    end

    repeat (2) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
